// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared types and constants.
// State encoding, default width and filter depth.
package pwm_capture_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int FILTER_LEN = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchroniser, optional stability filter,
// polarity fix and rising-edge detect. Filter: PWM_CAPTURE_FILTER_EN.
import pwm_capture_pkg::*;

module pwm_sync_edge #(
    parameter int INVERT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    localparam logic INV = (INVERT != 0);

    logic sync1;
    logic sync2;
    logic s_d;

    // two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [FILTER_LEN-2:0] hist;
    logic [FILTER_LEN-1:0] win;
    logic                  filt_q;
    logic                  filt;

    assign win  = {hist, sync2};
    assign filt = (&win)  ? 1'b1 :
                  (~|win) ? 1'b0 : filt_q;

    // sample history and held filter value
    always_ff @(posedge clk) begin
        if (reset) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[FILTER_LEN-3:0], sync2};
            filt_q <= filt;
        end
    end

    assign s = filt ^ INV;
`else
    assign s = sync2 ^ INV;
`endif

    // previous sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in clk cycles.
// Optional input glitch filter: PWM_CAPTURE_FILTER_EN.
import pwm_capture_pkg::*;

module pwm_capture #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH:0]   period,
    output logic             level_valid,
    output logic             locked
);

    localparam logic [WIDTH:0] CNT_MAX = '1;
    localparam logic [WIDTH:0] LVL_MAX = {1'b0, {WIDTH{1'b1}}};

    logic             s;
    logic             rise;
    state_t           state;
    logic [WIDTH:0]   per_cnt;
    logic [WIDTH:0]   hi_cnt;
    logic [WIDTH:0]   per_inc;
    logic [WIDTH:0]   hi_inc;
    logic [WIDTH-1:0] lvl_sat;
    logic             timeout;

    pwm_sync_edge #(
        .INVERT (INVERT)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise)
    );

    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;
    assign hi_inc  = (hi_cnt == CNT_MAX || !s) ? hi_cnt : hi_cnt + 1'b1;
    assign lvl_sat = (hi_cnt > LVL_MAX) ? '1 : hi_cnt[WIDTH-1:0];
    assign timeout = (per_cnt == CNT_MAX);

    // edge-driven FSM with period/high counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            per_cnt     <= '0;
            hi_cnt      <= '0;
            level       <= '0;
            period      <= '0;
            level_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            per_cnt     <= per_inc;
            hi_cnt      <= hi_inc;
            case (state)
                IDLE, MEASURE: begin
                    if (rise) begin
                        if (state == MEASURE) begin
                            period      <= per_cnt;
                            level       <= lvl_sat;
                            level_valid <= 1'b1;
                        end
                        state   <= MEASURE;
                        locked  <= 1'b1;
                        per_cnt <= {{WIDTH{1'b0}}, 1'b1};
                        hi_cnt  <= {{WIDTH{1'b0}}, 1'b1};
                    end else if (timeout) begin
                        state       <= STUCK;
                        locked      <= 1'b0;
                        level       <= s ? '1 : '0;
                        period      <= '0;
                        level_valid <= 1'b1;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state   <= MEASURE;
                        locked  <= 1'b1;
                        per_cnt <= {{WIDTH{1'b0}}, 1'b1};
                        hi_cnt  <= {{WIDTH{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (WIDTH=8), with an INVERT=1 copy.
// Filter checks build when PWM_CAPTURE_FILTER_EN is defined.
module tb_pwm_capture;

    logic       clk;
    logic       reset;
    logic       pwm;
    logic       pwm_inv;
    logic [7:0] level;
    logic [8:0] period;
    logic       level_valid;
    logic       locked;
    logic [7:0] level_i;
    logic [8:0] period_i;
    logic       lv_i;
    logic       locked_i;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int nstb = 0;
    int t_last = 0;
    int t_prev = 0;
    int lastlvl = 0;
    int lastper = 0;
    int lastlvl_i = 0;
    int lastper_i = 0;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    pwm_capture #(.WIDTH(8), .INVERT(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm),
        .level       (level),
        .period      (period),
        .level_valid (level_valid),
        .locked      (locked)
    );

    pwm_capture #(.WIDTH(8), .INVERT(1)) dut_inv (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_inv),
        .level       (level_i),
        .period      (period_i),
        .level_valid (lv_i),
        .locked      (locked_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (level_valid) begin
            nstb    = nstb + 1;
            t_prev  = t_last;
            t_last  = cyc_n;
            lastlvl = int'(level);
            lastper = int'(period);
        end
        if (lv_i) begin
            lastlvl_i = int'(level_i);
            lastper_i = int'(period_i);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic run_pwm(input int hi, input int per, input int n);
        repeat (n) begin
            pwm = 1'b1;
            cyc(hi);
            pwm = 1'b0;
            cyc(per - hi);
        end
    endtask

    task automatic test_reset();
        pwm = 1'b0;
        pwm_inv = 1'b1;
        do_reset();
        checks += 5;
        if (level !== 8'd0) begin
            errors++; $display("FAIL reset_level got %0d want 0", level);
        end
        if (period !== 9'd0) begin
            errors++; $display("FAIL reset_period got %0d want 0", period);
        end
        if (level_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", level_valid);
        end
        if (locked !== 1'b0) begin
            errors++; $display("FAIL reset_locked got %b want 0", locked);
        end
        if (locked_i !== 1'b0) begin
            errors++; $display("FAIL reset_locked_inv got %b want 0", locked_i);
        end
    endtask

    task automatic test_pwm64();
        int base;
        pwm = 1'b0;
        do_reset();
        base = nstb;
        run_pwm(64, 256, 4);
        checks += 5;
        if (nstb - base != 3) begin
            errors++; $display("FAIL p64_count got %0d want 3", nstb - base);
        end
        if (lastlvl != 64) begin
            errors++; $display("FAIL p64_level got %0d want 64", lastlvl);
        end
        if (lastper != 256) begin
            errors++; $display("FAIL p64_period got %0d want 256", lastper);
        end
        if (t_last - t_prev != 256) begin
            errors++; $display("FAIL p64_interval got %0d want 256", t_last - t_prev);
        end
        if (locked !== 1'b1) begin
            errors++; $display("FAIL p64_locked got %b want 1", locked);
        end
    endtask

    task automatic test_low();
        int base;
        int t0;
        pwm = 1'b0;
        do_reset();
        base = nstb;
        t0 = cyc_n;
        cyc(530);
        checks += 5;
        if (nstb - base != 1) begin
            errors++; $display("FAIL low_count got %0d want 1", nstb - base);
        end
        if (t_last - t0 < 505 || t_last - t0 > 520) begin
            errors++; $display("FAIL low_time got %0d want 505..520", t_last - t0);
        end
        if (lastlvl != 0) begin
            errors++; $display("FAIL low_level got %0d want 0", lastlvl);
        end
        if (lastper != 0) begin
            errors++; $display("FAIL low_period got %0d want 0", lastper);
        end
        if (locked !== 1'b0) begin
            errors++; $display("FAIL low_locked got %b want 0", locked);
        end
        cyc(600);
        checks++;
        if (nstb - base != 1) begin
            errors++; $display("FAIL low_repeat got %0d want 1", nstb - base);
        end
    endtask

    task automatic test_high();
        int base;
        pwm = 1'b1;
        do_reset();
        base = nstb;
        cyc(530);
        checks += 3;
        if (nstb - base != 1) begin
            errors++; $display("FAIL high_count got %0d want 1", nstb - base);
        end
        if (lastlvl != 255) begin
            errors++; $display("FAIL high_level got %0d want 255", lastlvl);
        end
        if (locked !== 1'b0) begin
            errors++; $display("FAIL high_locked got %b want 0", locked);
        end
        repeat (3) begin
            pwm = 1'b0;
            cyc(128);
            pwm = 1'b1;
            cyc(128);
        end
        checks += 4;
        if (nstb - base != 3) begin
            errors++; $display("FAIL half_count got %0d want 3", nstb - base);
        end
        if (lastlvl != 128) begin
            errors++; $display("FAIL half_level got %0d want 128", lastlvl);
        end
        if (lastper != 256) begin
            errors++; $display("FAIL half_period got %0d want 256", lastper);
        end
        if (locked !== 1'b1) begin
            errors++; $display("FAIL half_locked got %b want 1", locked);
        end
    endtask

    task automatic test_invert();
        pwm = 1'b0;
        pwm_inv = 1'b1;
        do_reset();
        cyc(10);
        repeat (4) begin
            pwm_inv = 1'b0;
            cyc(64);
            pwm_inv = 1'b1;
            cyc(192);
        end
        checks += 3;
        if (lastlvl_i != 64) begin
            errors++; $display("FAIL inv_level got %0d want 64", lastlvl_i);
        end
        if (lastper_i != 256) begin
            errors++; $display("FAIL inv_period got %0d want 256", lastper_i);
        end
        if (locked_i !== 1'b1) begin
            errors++; $display("FAIL inv_locked got %b want 1", locked_i);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        pwm = 1'b0;
        do_reset();
        run_pwm(64, 256, 3);
        pwm = 1'b1;
        cyc(64);
        pwm = 1'b0;
        cyc(36);
        reset = 1'b1;
        cyc(1);
        checks += 3;
        if (level !== 8'd0) begin
            errors++; $display("FAIL mid_level got %0d want 0", level);
        end
        if (period !== 9'd0) begin
            errors++; $display("FAIL mid_period got %0d want 0", period);
        end
        if (locked !== 1'b0) begin
            errors++; $display("FAIL mid_locked got %b want 0", locked);
        end
        reset = 1'b0;
        cyc(156);
        base = nstb;
        run_pwm(64, 256, 1);
        checks += 2;
        if (nstb - base != 0) begin
            errors++; $display("FAIL mid_first_rise got %0d want 0", nstb - base);
        end
        if (locked !== 1'b1) begin
            errors++; $display("FAIL mid_relock got %b want 1", locked);
        end
        run_pwm(64, 256, 1);
        checks += 3;
        if (nstb - base != 1) begin
            errors++; $display("FAIL mid_second_rise got %0d want 1", nstb - base);
        end
        if (lastlvl != 64) begin
            errors++; $display("FAIL mid_level2 got %0d want 64", lastlvl);
        end
        if (lastper != 256) begin
            errors++; $display("FAIL mid_period2 got %0d want 256", lastper);
        end
    endtask

    task automatic test_latency();
        int n;
        bit seen;
        pwm = 1'b0;
        cyc(4);
        pwm = 1'b1;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (level_valid) begin
                seen = 1'b1;
                n = i;
            end
        end
        checks += 2;
        if (!seen) begin
            errors++; $display("FAIL lat_timeout got none want strobe");
        end
        if (n != LAT) begin
            errors++; $display("FAIL lat_clocks got %0d want %0d", n, LAT);
        end
        cyc(10);
    endtask

`ifdef PWM_CAPTURE_FILTER_EN
    task automatic test_filter();
        int base;
        pwm = 1'b0;
        do_reset();
        base = nstb;
        repeat (5) begin
            pwm = 1'b1;
            cyc(2);
            pwm = 1'b0;
            cyc(10);
        end
        checks += 2;
        if (nstb - base != 0) begin
            errors++; $display("FAIL filt_glitch_strobe got %0d want 0", nstb - base);
        end
        if (locked !== 1'b0) begin
            errors++; $display("FAIL filt_glitch_locked got %b want 0", locked);
        end
        pwm = 1'b1;
        cyc(3);
        pwm = 1'b0;
        cyc(10);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL filt_pulse_locked got %b want 1", locked);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        pwm = 1'b0;
        pwm_inv = 1'b1;
        test_reset();
        test_pwm64();
        test_low();
        test_high();
        test_invert();
        test_reset_mid();
        test_latency();
`ifdef PWM_CAPTURE_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
